// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token literals (common with tmds_encoder),
// receiver FSM state type and the control-token classifier.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic       is_token;
    logic [1:0] cd;
  } tok_t;

  function automatic tok_t token_decode(input logic [9:0] sym);
    tok_t t;
    t = '{is_token: 1'b1, cd: 2'b00};
    case (sym)
      CTRL_TOK_00: t.cd = 2'b00;
      CTRL_TOK_01: t.cd = 2'b01;
      CTRL_TOK_10: t.cd = 2'b10;
      CTRL_TOK_11: t.cd = 2'b11;
      default:     t.is_token = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b symbol decode: control-token match plus the inverse of the
// TMDS transition-minimising data encoding.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_token,
  output logic [1:0] cd,
  output logic [7:0] vd
);

  tok_t       tok;
  logic [7:0] d;

  always_comb begin
    tok      = token_decode(sym);
    is_token = tok.is_token;
    cd       = tok.cd;
    // bit 9 flags DC-balance inversion, bit 8 selects XOR vs XNOR chaining
    d        = sym[9] ? ~sym[7:0] : sym[7:0];
    vd       = '0;
    vd[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      vd[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// Per-lane TMDS receiver: bit-slip alignment search, token-based lock and
// symbol decode. Optional lock-loss counter enabled by TMDS_RX_ERRCNT_EN.
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS = 8,
  parameter int DWELL       = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  in_word,
  output logic        locked,
  output logic [3:0]  slip_offset,
  output logic        vde,
  output logic [7:0]  vd,
  output logic [1:0]  cd,
  output logic [15:0] err_count
);

  localparam int DW = $clog2(DWELL + 1);
  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DW-1:0] WDOG_MAX   = DW'(DWELL);
  localparam logic [RW-1:0] RUN_LOCK   = RW'(LOCK_TOKENS);

  rx_state_t     state_q, state_d;
  logic [9:0]    prev_q, prev_d;
  logic [3:0]    off_q, off_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [DW-1:0] wdog_q, wdog_d;
  logic [RW-1:0] run_q, run_d;
  logic          locked_q, locked_d;
  logic          vde_q, vde_d;
  logic [7:0]    vd_q, vd_d;
  logic [1:0]    cd_q, cd_d;

  logic [19:0] hist;
  logic [9:0]  sym;
  logic        is_tok;
  logic [1:0]  tok_cd;
  logic [7:0]  dec_vd;
  logic [3:0]  off_next;

  assign hist     = {in_word, prev_q};
  assign sym      = 10'(hist >> off_q);
  assign off_next = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;

  tmds_symbol_decode u_dec (
    .sym      (sym),
    .is_token (is_tok),
    .cd       (tok_cd),
    .vd       (dec_vd)
  );

  always_comb begin
    state_d = state_q;
    prev_d  = in_word;
    off_d   = off_q;
    dwell_d = dwell_q;
    wdog_d  = wdog_q;
    run_d   = run_q;
    case (state_q)
      SEARCH: begin
        if (is_tok) begin
          dwell_d = '0;
          if (LOCK_TOKENS <= 1) begin
            state_d = LOCKED;
            wdog_d  = '0;
            run_d   = '0;
          end else begin
            state_d = CONFIRM;
            run_d   = RW'(1);
          end
        end else if (dwell_q == DWELL_LAST) begin
          off_d   = off_next;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      CONFIRM: begin
        if (is_tok) begin
          if (run_q + RW'(1) == RUN_LOCK) begin
            state_d = LOCKED;
            wdog_d  = '0;
            run_d   = '0;
          end else begin
            run_d = run_q + RW'(1);
          end
        end else begin
          // a broken run means this offset is wrong: move on immediately
          state_d = SEARCH;
          off_d   = off_next;
          dwell_d = '0;
          run_d   = '0;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          wdog_d = '0;
        end else if (wdog_q == WDOG_MAX) begin
          state_d = SEARCH;
          wdog_d  = '0;
          dwell_d = '0;
        end else begin
          wdog_d = wdog_q + DW'(1);
        end
      end
      default: state_d = SEARCH;
    endcase

    // outputs track the post-transition state so lock shows on the locking token
    locked_d = (state_d == LOCKED);
    vde_d    = 1'b0;
    vd_d     = '0;
    cd_d     = '0;
    if (locked_d) begin
      if (is_tok) begin
        cd_d = tok_cd;
      end else begin
        vde_d = 1'b1;
        vd_d  = dec_vd;
        cd_d  = cd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      off_q    <= '0;
      dwell_q  <= '0;
      wdog_q   <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      vde_q    <= 1'b0;
      vd_q     <= '0;
      cd_q     <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      off_q    <= off_d;
      dwell_q  <= dwell_d;
      wdog_q   <= wdog_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      vde_q    <= vde_d;
      vd_q     <= vd_d;
      cd_q     <= cd_d;
    end
  end

`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0] err_q, err_d;
  logic        lost;

  assign lost = (state_q == LOCKED) && !is_tok && (wdog_q == WDOG_MAX);

  always_comb begin
    err_d = err_q;
    if (lost && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0000;
`endif

  assign locked      = locked_q;
  assign slip_offset = off_q;
  assign vde         = vde_q;
  assign vd          = vd_q;
  assign cd          = cd_q;

endmodule
